// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Summary  : start/done handshake and operand/result bundle for seq_divider.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_divider_if;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, div_by_zero, quotient, remainder
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, div_by_zero, quotient, remainder
   );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Summary  : 32-bit restoring divider, one quotient bit per clock, with
//            start/done handshake. Signed operands enabled by DIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider (
   input  logic         clk,
   input  logic         reset_n,
   seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_FIXUP  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [32:0] r_rem;
   logic [31:0] r_q;
   logic [31:0] r_b_mag;
   logic [4:0]  r_cnt;
   logic        r_dbz;

   logic [32:0] w_rem_nxt;
   logic [31:0] w_q_nxt;
   logic [31:0] w_b_nxt;
   logic [4:0]  w_cnt_nxt;
   logic        w_dbz_nxt;

   logic        r_busy;
   logic        r_done;
   logic        r_div_by_zero;
   logic [31:0] r_quotient;
   logic [31:0] r_remainder;

   logic        w_done_nxt;
   logic        w_div_by_zero_nxt;
   logic [31:0] w_quotient_nxt;
   logic [31:0] w_remainder_nxt;

   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_q_res;
   logic [31:0] w_r_res;

   // One extra MSB on the difference acts as the borrow: set means trial < 0.
   logic [33:0] w_shifted;
   logic [33:0] w_diff;

   assign w_shifted = {r_rem, r_q[31]};
   assign w_diff    = w_shifted - {2'b00, r_b_mag};

`ifdef DIV_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;
   logic w_a_neg;
   logic w_b_neg;

   assign w_a_neg = bus.is_signed & bus.a[31];
   assign w_b_neg = bus.is_signed & bus.b[31];
   assign w_a_mag = w_a_neg ? (32'd0 - bus.a) : bus.a;
   assign w_b_mag = w_b_neg ? (32'd0 - bus.b) : bus.b;
   assign w_q_res = r_neg_q ? (32'd0 - r_q) : r_q;
   assign w_r_res = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
      end
   end
`else
   logic w_unused_is_signed;

   assign w_unused_is_signed = bus.is_signed;
   assign w_a_mag = bus.a;
   assign w_b_mag = bus.b;
   assign w_q_res = r_q;
   assign w_r_res = r_rem[31:0];
`endif

   always_comb begin
      w_state_nxt       = r_state;
      w_rem_nxt         = r_rem;
      w_q_nxt           = r_q;
      w_b_nxt           = r_b_mag;
      w_cnt_nxt         = r_cnt;
      w_dbz_nxt         = r_dbz;
      w_done_nxt        = 1'b0;
      w_div_by_zero_nxt = r_div_by_zero;
      w_quotient_nxt    = r_quotient;
      w_remainder_nxt   = r_remainder;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_rem_nxt = '0;
               w_b_nxt   = w_b_mag;
               w_cnt_nxt = 5'd31;
               if (bus.b == 32'd0) begin
                  // Divide is skipped, so the Q register carries the raw dividend to FIXUP.
                  w_dbz_nxt   = 1'b1;
                  w_q_nxt     = bus.a;
                  w_state_nxt = S_FIXUP;
               end else begin
                  w_dbz_nxt   = 1'b0;
                  w_q_nxt     = w_a_mag;
                  w_state_nxt = S_DIVIDE;
               end
            end
         end

         S_DIVIDE: begin
            if (!w_diff[33]) begin
               w_rem_nxt = w_diff[32:0];
               w_q_nxt   = {r_q[30:0], 1'b1};
            end else begin
               w_rem_nxt = w_shifted[32:0];
               w_q_nxt   = {r_q[30:0], 1'b0};
            end
            w_cnt_nxt = r_cnt - 5'd1;
            if (r_cnt == 5'd0) begin
               w_state_nxt = S_FIXUP;
            end
         end

         S_FIXUP: begin
            w_done_nxt        = 1'b1;
            w_div_by_zero_nxt = r_dbz;
            if (r_dbz) begin
               w_quotient_nxt  = 32'hFFFF_FFFF;
               w_remainder_nxt = r_q;
            end else begin
               w_quotient_nxt  = w_q_res;
               w_remainder_nxt = w_r_res;
            end
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_rem         <= '0;
         r_q           <= '0;
         r_b_mag       <= '0;
         r_cnt         <= '0;
         r_dbz         <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_div_by_zero <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_rem         <= w_rem_nxt;
         r_q           <= w_q_nxt;
         r_b_mag       <= w_b_nxt;
         r_cnt         <= w_cnt_nxt;
         r_dbz         <= w_dbz_nxt;
         r_busy        <= (w_state_nxt != S_IDLE);
         r_done        <= w_done_nxt;
         r_div_by_zero <= w_div_by_zero_nxt;
         r_quotient    <= w_quotient_nxt;
         r_remainder   <= w_remainder_nxt;
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_div_by_zero;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Summary  : Self-checking bench for seq_divider against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   seq_divider_if dif();

   seq_divider u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (dif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Truncating division done in 64 bits; the overflow case wraps naturally.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r, output logic dbz);
      longint sa;
      longint sb;
      dbz = (b == 32'd0);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (SIGNED_EN && s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dbz,
                         output int lat, output logic busy_mid, output logic busy_done);
      dif.a         = a;
      dif.b         = b;
      dif.is_signed = s;
      dif.start     = 1'b1;
      tick();
      dif.start = 1'b0;
      busy_mid  = dif.busy;
      lat       = 0;
      while (dif.done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      busy_done = dif.busy;
      q   = dif.quotient;
      r   = dif.remainder;
      dbz = dif.div_by_zero;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      dif.start = 1'b0;
      dif.a     = '0;
      dif.b     = '0;
      dif.is_signed = 1'b0;
      repeat (3) tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dif.busy); end
      checks++; if (dif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dif.done); end
      checks++; if (dif.div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", dif.div_by_zero); end
      checks++; if (dif.quotient !== 32'd0) begin failures++; $display("FAIL reset_quot got=%h exp=0", dif.quotient); end
      checks++; if (dif.remainder !== 32'd0) begin failures++; $display("FAIL reset_rem got=%h exp=0", dif.remainder); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      logic [31:0] ta [6] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd1234, 32'hFFFF_FFF9, 32'h8000_0000};
      logic [31:0] tb [6] = '{32'd7, 32'd1, 32'd9, 32'd0, 32'd2, 32'hFFFF_FFFF};
      logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] q, r, eq, er;
      logic        dbz, edbz, bm, bd;
      int          lat, elat;
      for (int i = 0; i < 6; i++) begin
         model(ta[i], tb[i], ts[i], eq, er, edbz);
         elat = (tb[i] == 32'd0) ? 1 : 33;
         run_op(ta[i], tb[i], ts[i], q, r, dbz, lat, bm, bd);
         checks++; if (lat !== elat) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
         checks++; if (q !== eq) begin failures++; $display("FAIL dir%0d_quot got=%h exp=%h", i, q, eq); end
         checks++; if (r !== er) begin failures++; $display("FAIL dir%0d_rem got=%h exp=%h", i, r, er); end
         checks++; if (dbz !== edbz) begin failures++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, dbz, edbz); end
         checks++; if (bm !== 1'b1 || bd !== 1'b0) begin failures++; $display("FAIL dir%0d_busy got=%b%b exp=10", i, bm, bd); end
         tick();
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, q, r, eq, er;
      logic        s, dbz, edbz, bm, bd;
      int          lat, elat, mode;
      for (int i = 0; i < 40; i++) begin
         a    = $urandom;
         s    = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 7);
         case (mode)
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 15);
            3:       b = 32'hFFFF_FFFF;
            4:       b = a >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if (mode == 3 && $urandom_range(0, 1) == 1) a = 32'h8000_0000;
         model(a, b, s, eq, er, edbz);
         elat = (b == 32'd0) ? 1 : 33;
         run_op(a, b, s, q, r, dbz, lat, bm, bd);
         checks++;
         if (lat !== elat || q !== eq || r !== er || dbz !== edbz || bd !== 1'b0) begin
            failures++;
            $display("FAIL rand%0d a=%h b=%h s=%b got q=%h r=%h z=%b lat=%0d exp q=%h r=%h z=%b lat=%0d",
                     i, a, b, s, q, r, dbz, lat, eq, er, edbz, elat);
         end
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      dif.a = 32'd100; dif.b = 32'd7; dif.is_signed = 1'b0; dif.start = 1'b1;
      tick();
      dif.start = 1'b0;
      lat = 0;
      repeat (9) begin tick(); lat++; end
      dif.a = 32'd50; dif.b = 32'd5; dif.start = 1'b1;
      tick();
      lat++;
      dif.start = 1'b0;
      while (dif.done !== 1'b1 && lat < 100) begin tick(); lat++; end
      checks++; if (lat !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
      checks++; if (dif.quotient !== 32'd14) begin failures++; $display("FAIL ignore_quot got=%0d exp=14", dif.quotient); end
      checks++; if (dif.remainder !== 32'd2) begin failures++; $display("FAIL ignore_rem got=%0d exp=2", dif.remainder); end
      repeat (3) tick();
      checks++; if (dif.done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", dif.done); end
      checks++; if (dif.quotient !== 32'd14) begin failures++; $display("FAIL hold_quot got=%0d exp=14", dif.quotient); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q, r;
      logic        dbz, bm, bd;
      int          lat;
      run_op(32'd100, 32'd7, 1'b0, q, r, dbz, lat, bm, bd);
      checks++; if (q !== 32'd14 || r !== 32'd2) begin failures++; $display("FAIL b2b_first got=%0d r %0d exp=14 r 2", q, r); end
      run_op(32'd50, 32'd5, 1'b0, q, r, dbz, lat, bm, bd);
      checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
      checks++; if (q !== 32'd10 || r !== 32'd0) begin failures++; $display("FAIL b2b_second got=%0d r %0d exp=10 r 0", q, r); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] q, r;
      logic        dbz, bm, bd, seen;
      int          lat;
      run_op(32'd77, 32'd0, 1'b0, q, r, dbz, lat, bm, bd);
      dif.a = 32'd100; dif.b = 32'd7; dif.is_signed = 1'b0; dif.start = 1'b1;
      tick();
      dif.start = 1'b0;
      repeat (14) tick();
      reset_n = 1'b0;
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", dif.busy); end
      checks++; if (dif.div_by_zero !== 1'b0) begin failures++; $display("FAIL midrst_dbz got=%b exp=0", dif.div_by_zero); end
      checks++; if (dif.quotient !== 32'd0 || dif.remainder !== 32'd0) begin
         failures++; $display("FAIL midrst_outputs got q=%h r=%h exp=0", dif.quotient, dif.remainder); end
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (50) begin
         tick();
         if (dif.done === 1'b1 || dif.busy === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
